// File: rtl/vid_scanout_if.sv
// Line-memory read bus between the scanout engine (master) and the line buffer (slave).
// Read data is combinationally presented for the address issued on the previous clk.
interface vid_scanout_if;
  logic [19:0] vid_addr;
  logic        vid_ren;
  logic [23:0] vid_data_in;

  modport master (output vid_addr, output vid_ren, input vid_data_in);
  modport slave  (input vid_addr, input vid_ren, output vid_data_in);
endinterface

// File: rtl/vid_scanout.sv
// Panel scanout: raster counters on pix_en, line-memory read (stage 1), pixel/sync output (stage 2).
// Reports the last read address and a start-of-vblank pulse so the renderer can stay ahead.
module vid_scanout #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 320,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_en,
  vid_scanout_if.master        mem,
  output logic [19:0]          curr_vid_addr,
  output logic                 next_field,
  output logic                 hsync_n,
  output logic                 vsync_n,
  output logic                 de,
  output logic [23:0]          rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_r;
  logic [10:0] v_r;
  logic [19:0] vid_addr_r;
  logic        vid_ren_r;
  logic        s2_valid_r;
  logic        s2_act_r;
  logic        s2_hs_r;
  logic        s2_vs_r;

  logic        active_s;
  logic        hs_s;
  logic        vs_s;
  logic        field_s;
  logic [19:0] addr_s;

  assign mem.vid_addr = vid_addr_r;
  assign mem.vid_ren  = vid_ren_r;

  // Decode the current raster position; vsync depends on v only, so it is whole-line.
  always_comb begin
    active_s = (h_r < H_ACT) && (v_r < V_ACT);
    hs_s     = (h_r >= HS_BEG) && (h_r < HS_END);
    vs_s     = (v_r >= VS_BEG) && (v_r < VS_END);
    field_s  = (h_r == 10'd0) && (v_r == V_ACT);
    addr_s   = {v_r, h_r[8:0]};
  end

  // Raster counters, advanced only on pixel strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_r <= 10'd0;
      v_r <= 11'd0;
    end else if (pix_en) begin
      if (h_r == H_LAST) begin
        h_r <= 10'd0;
        v_r <= (v_r == V_LAST) ? 11'd0 : v_r + 11'd1;
      end else begin
        h_r <= h_r + 10'd1;
      end
    end else begin
      h_r <= h_r;
      v_r <= v_r;
    end
  end

  // Stage 1: issue the line-memory read and capture the flags for stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_ren_r     <= 1'b0;
      next_field    <= 1'b0;
      vid_addr_r    <= 20'd0;
      curr_vid_addr <= 20'd0;
      s2_valid_r    <= 1'b0;
      s2_act_r      <= 1'b0;
      s2_hs_r       <= 1'b0;
      s2_vs_r       <= 1'b0;
    end else begin
      vid_ren_r  <= pix_en & active_s;
      next_field <= pix_en & field_s;
      s2_valid_r <= pix_en;
      // Addresses hold through blanking so curr_vid_addr keeps the last pixel read.
      if (pix_en && active_s) begin
        vid_addr_r    <= addr_s;
        curr_vid_addr <= addr_s;
      end
      if (pix_en) begin
        s2_act_r <= active_s;
        s2_hs_r  <= hs_s;
        s2_vs_r  <= vs_s;
      end
    end
  end

  // Stage 2: present pixel data and syncs one clk after the read, hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      de      <= 1'b0;
      rgb     <= 24'd0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else if (s2_valid_r) begin
      de      <= s2_act_r;
      rgb     <= s2_act_r ? mem.vid_data_in : 24'd0;
      hsync_n <= ~s2_hs_r;
      vsync_n <= ~s2_vs_r;
    end
  end

endmodule

// File: tb/tb_vid_scanout.sv
// Self-checking bench for vid_scanout with tiny raster parameters and randomized pixel strobes.
// The reference derives every pixel position from the count of strobes since reset.
module tb_vid_scanout;
  localparam int HA = 8, HF = 1, HS = 1, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [19:0] curr_vid_addr;
  logic        next_field, hsync_n, vsync_n, de;
  logic [23:0] rgb;
  logic [23:0] seed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vid_scanout_if bus ();

  function automatic logic [23:0] mem_f(input logic [19:0] a, input logic [23:0] s);
    return {a[11:0], ~a[11:0]} ^ s;
  endfunction

  // Line memory: data for the issued address is available for capture on the next edge.
  assign bus.vid_data_in = mem_f(bus.vid_addr, seed);

  vid_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mem(bus),
    .curr_vid_addr(curr_vid_addr), .next_field(next_field),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .rgb(rgb)
  );

  // Reference state: strobe count since reset and the pixel awaiting output.
  int          k;
  bit          p_valid;
  int          p_h, p_v;
  logic        exp_ren, exp_nf, exp_de, exp_hs_n, exp_vs_n;
  logic [19:0] exp_addr, exp_curr;
  logic [23:0] exp_rgb;

  task automatic tick(input bit rst, input bit pe);
    int  h, v;
    bit  act;
    reset  = rst;
    pix_en = pe;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; p_valid = 0;
      exp_ren = 0; exp_nf = 0; exp_de = 0; exp_hs_n = 1; exp_vs_n = 1;
      exp_addr = 20'd0; exp_curr = 20'd0; exp_rgb = 24'd0;
    end else begin
      if (p_valid) begin
        act      = (p_h < HA) && (p_v < VA);
        exp_de   = act;
        exp_rgb  = act ? mem_f({11'(p_v), 9'(p_h)}, seed) : 24'd0;
        exp_hs_n = !((p_h >= HA + HF) && (p_h < HA + HF + HS));
        exp_vs_n = !((p_v >= VA + VF) && (p_v < VA + VF + VS));
      end
      if (pe) begin
        h = k % HT;
        v = (k / HT) % VT;
        act = (h < HA) && (v < VA);
        exp_ren = act;
        exp_nf  = (h == 0) && (v == VA);
        if (act) begin
          exp_addr = {11'(v), 9'(h)};
          exp_curr = exp_addr;
        end
        p_valid = 1; p_h = h; p_v = v;
        k++;
      end else begin
        exp_ren = 0; exp_nf = 0; p_valid = 0;
      end
    end
  endtask

  task automatic test_reset();
    tick(1, 0);
    tick(1, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      total++;
      if ({bus.vid_ren, next_field, de, hsync_n, vsync_n} !== 5'b00011) begin
        bad++; $display("FAIL reset.flags got=%b want=00011", {bus.vid_ren, next_field, de, hsync_n, vsync_n});
      end
      total++;
      if ({bus.vid_addr, curr_vid_addr, rgb} !== 64'd0) begin
        bad++; $display("FAIL reset.data got=%h/%h/%h want=0", bus.vid_addr, curr_vid_addr, rgb);
      end
    end
  endtask

  // mode 0: strobe every clk, 1: every 3rd clk, 2: random strobes
  task automatic test_pixel_stream(input int mode, input int events, input string name);
    int cyc = 0, n_reads = 0, de_cnt = 0;
    bit pe;
    logic [19:0] want_addr;
    tick(1, 0);
    while (k < events) begin
      if (cyc > events * 4 + 100) begin
        total++; bad++;
        $display("FAIL %s.timeout got=%0d want=%0d strobes", name, k, events);
        break;
      end
      pe = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      tick(0, pe);
      cyc++;
      total++;
      if (bus.vid_ren !== exp_ren) begin
        bad++; $display("FAIL %s.ren cyc=%0d got=%b want=%b", name, cyc, bus.vid_ren, exp_ren);
      end
      total++;
      if (bus.vid_addr !== exp_addr) begin
        bad++; $display("FAIL %s.addr cyc=%0d got=%h want=%h", name, cyc, bus.vid_addr, exp_addr);
      end
      total++;
      if (curr_vid_addr !== exp_curr) begin
        bad++; $display("FAIL %s.curr cyc=%0d got=%h want=%h", name, cyc, curr_vid_addr, exp_curr);
      end
      total++;
      if (next_field !== exp_nf) begin
        bad++; $display("FAIL %s.nf cyc=%0d got=%b want=%b", name, cyc, next_field, exp_nf);
      end
      total++;
      if (de !== exp_de) begin
        bad++; $display("FAIL %s.de cyc=%0d got=%b want=%b", name, cyc, de, exp_de);
      end
      total++;
      if (rgb !== exp_rgb) begin
        bad++; $display("FAIL %s.rgb cyc=%0d got=%h want=%h", name, cyc, rgb, exp_rgb);
      end
      total++;
      if ({hsync_n, vsync_n} !== {exp_hs_n, exp_vs_n}) begin
        bad++; $display("FAIL %s.sync cyc=%0d got=%b want=%b", name, cyc, {hsync_n, vsync_n}, {exp_hs_n, exp_vs_n});
      end
      if (de === 1'b1) de_cnt++;
      if (bus.vid_ren === 1'b1 && n_reads < 16) begin
        want_addr = (n_reads < 8) ? 20'(n_reads) : 20'(32'h200 + n_reads - 8);
        total++;
        if (bus.vid_addr !== want_addr) begin
          bad++; $display("FAIL %s.seq%0d got=%h want=%h", name, n_reads, bus.vid_addr, want_addr);
        end
        n_reads++;
      end
    end
    if (mode == 0) begin
      total++;
      if (de_cnt != (events / (HT * VT)) * HA * VA) begin
        bad++; $display("FAIL %s.de_count got=%0d want=%0d", name, de_cnt, (events / (HT * VT)) * HA * VA);
      end
    end
  endtask

  task automatic test_next_field();
    int  pulses = 0;
    bit  in_blank = 0;
    tick(1, 0);
    for (int i = 0; i < 2 * HT * VT + 5; i++) begin
      tick(0, 1);
      if (next_field === 1'b1) begin
        pulses++;
        in_blank = 1;
        total++;
        if (curr_vid_addr !== 20'h607) begin
          bad++; $display("FAIL nf.curr_at_pulse got=%h want=607", curr_vid_addr);
        end
      end else if (in_blank && bus.vid_ren === 1'b1) begin
        in_blank = 0;
        total++;
        if (curr_vid_addr !== 20'h000) begin
          bad++; $display("FAIL nf.curr_first_read got=%h want=000", curr_vid_addr);
        end
      end else if (in_blank && curr_vid_addr !== 20'h607) begin
        total++; bad++;
        $display("FAIL nf.curr_blank got=%h want=607", curr_vid_addr);
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL nf.pulses got=%0d want=2", pulses);
    end
  endtask

  task automatic test_sync();
    int h = 0, v = 0;
    bit have_prev = 0;
    tick(1, 0);
    for (int i = 0; i < HT * VT + 2; i++) begin
      tick(0, 1);
      if (have_prev) begin
        total++;
        if (hsync_n !== (h != 9) || vsync_n !== (v != 5)) begin
          bad++; $display("FAIL sync h=%0d v=%0d got=%b%b want=%b%b", h, v, hsync_n, vsync_n, (h != 9), (v != 5));
        end
        h++;
        if (h == HT) begin h = 0; v = (v + 1) % VT; end
      end
      have_prev = 1;
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0);
    for (int i = 0; i < 2 * HT + 5; i++) tick(0, 1);
    tick(1, 1);
    total++;
    if (bus.vid_ren !== 1'b0 || de !== 1'b0) begin
      bad++; $display("FAIL reset_mid.outputs got=%b%b want=00", bus.vid_ren, de);
    end
    tick(0, 0);
    tick(0, 1);
    total++;
    if (bus.vid_ren !== 1'b1 || bus.vid_addr !== 20'h000) begin
      bad++; $display("FAIL reset_mid.first_read got=%b/%h want=1/000", bus.vid_ren, bus.vid_addr);
    end
  endtask

  initial begin
    seed   = 24'($urandom);
    reset  = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_pixel_stream(0, 2 * HT * VT, "every_clk");
    test_pixel_stream(1, HT * VT + 20, "every_3rd");
    test_pixel_stream(2, 2 * HT * VT, "random");
    test_next_field();
    test_sync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
